// File: rtl/fifo_access_arbiter_pkg.sv
// fifo_arb_pkg: shared types, op encodings and pointer helper for the FIFO access arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} arb_state_t;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int PTR_W = 3;
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return (int'(p) >= n - 1) ? '0 : p + PTR_W'(1);
  endfunction
endpackage

// File: rtl/fifo_access_arbiter_if.sv
// fifo_access_arbiter_if: requester/flag side (master) and arbiter side (slave) of the shared FIFO access bus
interface fifo_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 4
);
  logic [NUM_REQ-1:0] req, wr_sel, grant;
  logic full, empty, wen, ren, ack, nack, busy, flag_err;
  logic [CNT_W-1:0] count;
  modport master (output req, wr_sel, full, empty, input wen, ren, grant, ack, nack, busy, count, flag_err);
  modport slave (input req, wr_sel, full, empty, output wen, ren, grant, ack, nack, busy, count, flag_err);
endinterface

// File: rtl/fifo_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first pending bit at or above ptr with wrap
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [PTR_W-1:0]   o_winner
);
  logic [NUM_REQ-1:0] w_rot;
  assign w_rot = (i_pending >> i_ptr) | (i_pending << (NUM_REQ - int'(i_ptr)));
  assign o_valid = |i_pending;
  // scan downward so the lowest rotated offset (closest to ptr) is assigned last and wins
  always_comb begin
    o_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) o_winner = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
  end
endmodule

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: edge-captured round-robin sharing of one FIFO's wen/ren with shadow occupancy check
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic clock,
  input logic resetn,
  fifo_access_arbiter_if.slave bus
);
  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_req_d, r_pending, r_op;
  logic [PTR_W-1:0]   r_ptr, r_win;
  logic [CNT_W-1:0]   r_count;
  logic               r_flag_err;
  logic               w_valid, w_issue, w_wr, w_wen, w_ren, w_at_full, w_at_zero;
  logic [PTR_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_onehot, w_clr, w_take;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_pending(r_pending),
    .i_ptr(r_ptr),
    .o_valid(w_valid),
    .o_winner(w_pick)
  );

  assign w_issue = r_state == ISSUE;
  assign w_onehot = NUM_REQ'(1) << r_win;
  assign w_wr = |(r_op & w_onehot);
  assign w_wen = w_issue & (w_wr == OP_WRITE) & ~bus.full;
  assign w_ren = w_issue & (w_wr == OP_READ) & ~bus.empty;
  assign w_at_full = r_count == CNT_W'(DEPTH);
  assign w_at_zero = r_count == '0;
  assign w_clr = w_issue ? w_onehot : '0;
  assign w_take = bus.req & ~r_req_d & (~r_pending | w_clr);

  assign bus.wen = w_wen;
  assign bus.ren = w_ren;
  assign bus.ack = w_wen | w_ren;
  assign bus.nack = w_issue & ~(w_wen | w_ren);
  assign bus.grant = w_issue ? w_onehot : '0;
  assign bus.busy = r_state != IDLE;
  assign bus.count = r_count;
  assign bus.flag_err = r_flag_err;

  // edge capture; req_d resets high so a req held through reset is not seen as a new edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_req_d <= '1;
      r_pending <= '0;
      r_op <= '0;
    end else begin
      r_req_d <= bus.req;
      r_pending <= (r_pending & ~w_clr) | w_take;
      r_op <= (r_op & ~w_take) | (bus.wr_sel & w_take);
    end
  end

  // arbitration FSM: pick in IDLE, issue for one cycle, then one settle cycle for the flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_win <= '0;
      r_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_win <= w_pick;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_ptr <= ptr_inc(r_win, NUM_REQ);
          r_state <= COOLDOWN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // shadow occupancy and sticky disagreement flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_flag_err <= 1'b0;
    end else begin
      if (w_wen && !w_at_full) r_count <= r_count + CNT_W'(1);
      else if (w_ren && !w_at_zero) r_count <= r_count - CNT_W'(1);
      if (w_issue && ((bus.full != w_at_full) || (bus.empty != w_at_zero) || (w_wen && w_at_full) || (w_ren && w_at_zero)))
        r_flag_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: directed table-driven and sequence checks of the FIFO access arbiter
module tb_fifo_access_arbiter;
  typedef struct {
    logic [3:0] req, wr;
    logic       wen, ren;
    logic [3:0] grant;
    logic       ack, nack, busy;
    logic [3:0] count;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] wr_sel = 4'b0000;
  int checks = 0;
  int errors = 0;
  int unsigned fcnt;
  vec_t tv[$];

  fifo_access_arbiter_if #(.NUM_REQ(4), .CNT_W(4)) bus();

  fifo_access_arbiter #(.NUM_REQ(4), .DEPTH(8), .CNT_W(4)) dut (
    .clock(clk),
    .resetn(resetn),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.req = req;
  assign bus.wr_sel = wr_sel;
  assign bus.full = fcnt == 8;
  assign bus.empty = fcnt == 0;

  // 8-entry FIFO flag model: commits on the edge that closes the wen/ren pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fcnt <= 0;
    else if (bus.wen && fcnt < 8) fcnt <= fcnt + 1;
    else if (bus.ren && fcnt > 0) fcnt <= fcnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic we, input logic re,
                              input logic [3:0] g, input logic a, input logic n, input logic b, input logic [3:0] c);
    vec_t v;
    v.req = r; v.wr = w; v.wen = we; v.ren = re; v.grant = g; v.ack = a; v.nack = n; v.busy = b; v.count = c;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {19'd0, bus.wen, bus.ren, bus.grant, bus.ack, bus.nack, bus.busy, bus.count, bus.flag_err};
  endfunction

  task automatic run_tv(input string nm);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      req = tv[i].req;
      wr_sel = tv[i].wr;
      @(negedge clk);
      chk($sformatf("%s[%0d] {wen,ren,grant,ack,nack,busy,count,ferr}", nm, i), outs(),
          {19'd0, tv[i].wen, tv[i].ren, tv[i].grant, tv[i].ack, tv[i].nack, tv[i].busy, tv[i].count, 1'b0});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // one request edge on requester idx; expects the grant three samples after the raise
  task automatic op(input int idx, input logic wr, input logic exp_ack, input string nm);
    int n;
    @(posedge clk); #1;
    req[idx] = 1'b1;
    wr_sel[idx] = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant == 4'b0000 && n < 10);
    chk({nm, " latency"}, n, 3);
    chk({nm, " grant"}, bus.grant, 4'b0001 << idx);
    chk({nm, " {wen,ren,ack,nack}"}, {bus.wen, bus.ren, bus.ack, bus.nack},
        {wr & exp_ack, ~wr & exp_ack, exp_ack, ~exp_ack});
    @(posedge clk); #1;
    req[idx] = 1'b0;
  endtask

  initial begin
    req = 4'b1111;
    wr_sel = 4'b1111;
    #2 resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset outputs", outs(), 32'd0);
    end
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post-reset held req {busy,grant}", {bus.busy, bus.grant}, 5'b0);
    end
    req = 4'b0000;

    tv.delete();
    tv.push_back(mk(4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 0, 1, 4'd0));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 1, 4'd1));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'd1));
    tv.push_back(mk(4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'd1));
    run_tv("single_write");
    chk("single_write empty", bus.empty, 1'b0);

    do_reset();
    for (int i = 0; i < 9; i++) op(1, 1'b1, i < 8, $sformatf("fill%0d", i));
    @(negedge clk);
    chk("fill {count,full,ferr}", {bus.count, bus.full, bus.flag_err}, {4'd8, 1'b1, 1'b0});
    for (int i = 0; i < 9; i++) op(2, 1'b0, i < 8, $sformatf("drain%0d", i));
    @(negedge clk);
    chk("drain {count,empty,ferr}", {bus.count, bus.empty, bus.flag_err}, {4'd0, 1'b1, 1'b0});

    do_reset();
    op(3, 1'b0, 1'b0, "empty_read");
    @(negedge clk);
    chk("empty_read {count,ferr}", {bus.count, bus.flag_err}, 5'b0);

    do_reset();
    tv.delete();
    tv.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd0));
    tv.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0001, 1, 0, 1, 4'd0));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd1));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd1));
    tv.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0010, 1, 0, 1, 4'd1));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd2));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd2));
    tv.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0100, 1, 0, 1, 4'd2));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd3));
    tv.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd3));
    tv.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b1000, 1, 0, 1, 4'd3));
    tv.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd4));
    tv.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd4));
    tv.push_back(mk(4'b0101, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd4));
    tv.push_back(mk(4'b0101, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd4));
    tv.push_back(mk(4'b0101, 4'b1111, 1, 0, 4'b0001, 1, 0, 1, 4'd4));
    tv.push_back(mk(4'b0101, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd5));
    tv.push_back(mk(4'b0101, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd5));
    tv.push_back(mk(4'b0101, 4'b1111, 1, 0, 4'b0100, 1, 0, 1, 4'd5));
    tv.push_back(mk(4'b0101, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 4'd6));
    tv.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'd6));
    run_tv("round_robin");

    do_reset();
    begin
      int n;
      @(posedge clk); #1;
      req[0] = 1'b1;
      wr_sel[0] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.grant == 4'b0000 && n < 10);
      chk("abort pre wen", bus.wen, 1'b1);
      resetn = 1'b0;
      #1;
      chk("abort async {wen,grant,ack,busy}", {bus.wen, bus.grant, bus.ack, bus.busy}, 7'b0);
      repeat (2) @(negedge clk);
      chk("abort count", bus.count, 4'd0);
      resetn = 1'b1;
      repeat (6) begin
        @(negedge clk);
        chk("abort held req busy", bus.busy, 1'b0);
      end
      @(posedge clk); #1;
      req[0] = 1'b0;
    end
    op(0, 1'b1, 1'b1, "reraise");
    @(negedge clk);
    chk("reraise {count,ferr}", {bus.count, bus.flag_err}, {4'd1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Shares one FIFO (control/flag datapath: wen/ren in, full/empty out) among NUM_REQ requesters.
- Each requester raises a level request plus a write/read select.
- Block edge-captures requests and picks one per slot round-robin.
- Issues a single-cycle wen or ren only when legal (not full / not empty), returns ack/nack, and keeps a shadow occupancy count for consistency checking.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DEPTH, 8, FIFO entries; count saturates here
CNT_W, 4, width of count output; must hold DEPTH

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; rising edge = one operation
wr_sel  in  NUM_REQ  per requester: 1 = write, 0 = read; sampled with the req edge
full  in  1  FIFO full flag from flag logic
empty  in  1  FIFO empty flag from flag logic
wen  out  1  one-cycle write enable to FIFO
ren  out  1  one-cycle read enable to FIFO
grant  out  NUM_REQ  one-hot, high in the ISSUE cycle for the served requester
ack  out  1  high in ISSUE cycle when wen or ren issued
nack  out  1  high in ISSUE cycle when the op was refused (full/empty)
busy  out  1  high in ISSUE and COOLDOWN
count  out  CNT_W  shadow occupancy 0..DEPTH
flag_err  out  1  sticky; flags disagree with shadow count

Behaviour:
- Reset: clock and reset are fixed. There is one clock, `clock`. Reset is asynchronous and active-low on `resetn`. Asserting resetn low clears every register immediately, with no clock needed. Cleared state: state=IDLE, pending=0, op bits=0, rr pointer=0, count=0, flag_err=0. Outputs wen, ren, grant, ack, nack and busy all go to 0 at once.
- Edge capture:
  - req_d holds req delayed one cycle.
  - When req[i] & ~req_d[i], set pending[i] and latch op[i]=wr_sel[i].
  - A rising edge on an already-pending requester is ignored; op is not overwritten.
  - If a set and a clear of pending[i] fall in the same cycle, the set wins, so no request is lost.
- FSM states: IDLE, ISSUE, COOLDOWN.
  - IDLE: if pending≠0, register winner = first set bit searching from rr pointer upward with wrap, then go to ISSUE. Otherwise stay.
  - ISSUE, one cycle, outputs decoded from registered winner and live full/empty:
    - Write and !full: wen=1, ack=1.
    - Write and full: nack=1.
    - Read and !empty: ren=1, ack=1.
    - Read and empty: nack=1.
    - In all cases: grant[winner]=1; at the edge, clear pending[winner], set rr pointer=(winner+1) mod NUM_REQ, and go to COOLDOWN.
  - COOLDOWN, one cycle: lets the registered full/empty settle, then go to IDLE.
- wen and ren are never high together. At most one op is issued per 3 cycles.
- Latency: pending is set at edge E0, ISSUE is entered at E1, and wen/ren are high between E1 and E2. The FIFO commits at E2.
- Shadow count: +1 on wen, −1 on ren, saturating at 0 and DEPTH.
- flag_err is set (sticky until reset) in any of these cases:
  - In ISSUE, full != (count==DEPTH).
  - In ISSUE, empty != (count==0).
  - A wen is issued with count==DEPTH.
  - A ren is issued with count==0.
- Reset mid-ISSUE aborts the op: wen/ren drop asynchronously, the pending request is discarded, and the requester must re-raise req.

Decomposition:
- Package fifo_arb_pkg holds:
  - enum arb_state_t {IDLE, ISSUE, COOLDOWN}
  - localparams OP_READ=1'b0, OP_WRITE=1'b1
  - a function for the mod-NUM_REQ pointer increment
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: pending[NUM_REQ], ptr.
  - Outputs: valid, winner index.
  - Verified standalone.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with req=4'b1111 → wen=ren=grant=ack=nack=busy=0 and count=0. After release, with no new edges, no op issues.
2. Single write: req[0] rises with wr_sel[0]=1 and the FIFO empty → exactly one wen, two edges later. grant=4'b0001 and ack=1 in the same cycle, then count=1, empty drops.
3. Fill overflow: 9 separate write edges on req[1] → 8 wen+ack pulses, 9th gives nack with wen=0, full=1, count=8, flag_err=0.
4. Round robin: req[3:0] all rise in the same cycle as writes → grants 0001, 0010, 0100, 1000 spaced 3 cycles apart. Then req[2] and req[0] rise together → req[0] served first (pointer=0), then req[2].
5. Drain underflow: after the fill, 9 read edges on req[2] → 8 ren pulses, 9th gives nack with ren=0, empty=1, count=0. A read on an empty FIFO from reset also gives nack.
6. Reset mid-op: pull resetn low during the ISSUE cycle of a write → wen falls in the same cycle, count stays 0, pending clears. Release with req still high → no op until req falls and re-rises.
